dffre_cell: RTL and testbench

- Single-clock D flip-flop bank with synchronous active-low reset and clock enable.
- Acts as the leaf storage cell used in golden-vs-post-route equivalence checks.
- The post-route netlist of this block must be cycle-identical to the RTL.
- Default configuration is 1 bit wide.

---
 rtl/dffre_cell_pkg.sv | 7 +
 rtl/dffre_bit.sv | 32 +++
 rtl/dffre_cell.sv | 41 ++++
 tb/tb_dffre_cell.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dffre_cell_pkg.sv
// rtl/dffre_cell_pkg.sv - shared constants for the dffre_cell storage bank
package dffre_cell_pkg;

    // Default per-bit reset level; the top replicates it across WIDTH bits.
    localparam logic DFFRE_DEFAULT_RESET = 1'b0;

endpackage : dffre_cell_pkg

// File: rtl/dffre_bit.sv
// rtl/dffre_bit.sv - single flop with sync active-low reset and clock enable
//
// Ports:
//   clk          rising-edge clock
//   i_Reset      synchronous reset, active-low
//   i_Enable     clock enable, active-high
//   i_ResetValue level loaded while i_Reset is low
//   i_D          data input
//   o_Q          registered output, driven straight from the flop
module dffre_bit (
    input  logic clk,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_ResetValue,
    input  logic i_D,
    output logic o_Q
);

    logic r_q;

    // Reset dominates enable; with enable low the flop holds.
    always_ff @(posedge clk) begin
        if (!i_Reset) begin
            r_q <= i_ResetValue;
        end else if (i_Enable) begin
            r_q <= i_D;
        end
    end

    assign o_Q = r_q;

endmodule : dffre_bit

// File: rtl/dffre_cell.sv
// rtl/dffre_cell.sv - WIDTH-bit D flop bank with sync active-low reset and enable
//
// Parameters:
//   WIDTH        number of independent storage bits
//   RESET_VALUE  value loaded into o_Q while i_Reset is low
// Ports:
//   clk       rising-edge clock
//   i_Reset   synchronous reset, active-low
//   i_Enable  clock enable, active-high
//   i_D       data input, WIDTH bits
//   o_Q       registered output, WIDTH bits
module dffre_cell
    import dffre_cell_pkg::*;
#(
    parameter int unsigned             WIDTH       = 1,
    parameter logic [WIDTH-1:0]        RESET_VALUE = {WIDTH{DFFRE_DEFAULT_RESET}}
) (
    input  logic             clk,
    input  logic             i_Reset,
    input  logic             i_Enable,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] w_q;

    // One leaf cell per bit so each maps to its own library DFFRE primitive.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        dffre_bit u_bit (
            .clk          (clk),
            .i_Reset      (i_Reset),
            .i_Enable     (i_Enable),
            .i_ResetValue (RESET_VALUE[g]),
            .i_D          (i_D[g]),
            .o_Q          (w_q[g])
        );
    end

    assign o_Q = w_q;

endmodule : dffre_cell

// File: tb/tb_dffre_cell.sv
// tb/tb_dffre_cell.sv - directed self-checking bench for dffre_cell
module tb_dffre_cell;

    logic clk;
    logic i_Reset;
    logic i_Enable;
    logic [0:0] i_D;
    logic [0:0] o_Q;

    int checks;
    int failures;
    logic [0:0] exp_q;

    dffre_cell dut (
        .clk      (clk),
        .i_Reset  (i_Reset),
        .i_Enable (i_Enable),
        .i_D      (i_D),
        .o_Q      (o_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [0:0] expected);
        checks++;
        assert (o_Q === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o_Q, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Power-up under reset with enable low and data high.
        i_Reset  = 1'b0;
        i_Enable = 1'b0;
        i_D      = 1'b1;
        tick();
        check("reset_powerup", 1'b0);

        // Out of reset, enable low: hold zero over several edges.
        i_Reset = 1'b1;
        tick();
        check("hold_after_reset_0", 1'b0);
        tick();
        check("hold_after_reset_1", 1'b0);
        tick();
        check("hold_after_reset_2", 1'b0);

        // Enabled loads.
        i_Enable = 1'b1;
        i_D      = 1'b1;
        tick();
        check("load_1", 1'b1);
        i_D = 1'b0;
        tick();
        check("load_0", 1'b0);
        i_D = 1'b1;
        tick();
        check("load_1_again", 1'b1);

        // Enable low: data toggling is ignored.
        i_Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_D = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check("hold_toggle", 1'b1);
        end
        // Enable glitch between edges must not load.
        i_D = 1'b0;
        #1 i_Enable = 1'b1;
        #1 i_Enable = 1'b0;
        tick();
        check("enable_glitch", 1'b1);

        i_Enable = 1'b1;
        i_D      = 1'b0;
        tick();
        check("reenable_load_0", 1'b0);

        // Mid-operation reset beats enable and data.
        i_D = 1'b1;
        tick();
        check("preload_1", 1'b1);
        i_Reset = 1'b0;
        tick();
        check("reset_mid_op", 1'b0);
        i_Reset = 1'b1;
        tick();
        check("reset_release_load", 1'b1);

        // Reset release with enable low stays at reset value.
        i_Reset = 1'b0;
        tick();
        check("reset_again", 1'b0);
        i_Reset  = 1'b1;
        i_Enable = 1'b0;
        tick();
        check("release_enable_low", 1'b0);

        // Random data stream, enabled and out of reset.
        i_Enable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            i_D   = 1'($urandom_range(0, 1));
            exp_q = i_D;
            tick();
            check("random_stream", exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dffre_cell
